// File: rtl/tr_pkg.sv
// rtl/tr_pkg.sv - shared sizing and occupancy-state types for the delta sample FIFO
package tr_pkg;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_e;
endpackage

// File: rtl/tr_fifo_mem.sv
// rtl/tr_fifo_mem.sv - sample storage, read/write pointers and occupancy counter
module tr_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   occ
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is deliberately unreset; only pointers and occupancy carry state.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/tr_delta_fifo.sv
// rtl/tr_delta_fifo.sv - captures upstream count raw or as delta, queues samples, counts drops
module tr_delta_fifo
  import tr_pkg::*;
#(
  parameter int W = tr_pkg::W,
  parameter int DEPTH = tr_pkg::DEPTH,
  parameter int AW = tr_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  cnt,
  input  logic          a,
  input  logic          b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          full,
  output logic [7:0]    drop_cnt
);
  localparam logic [AW:0] OCC_FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0] last_cnt;
  logic [W-1:0] val;
  logic [AW:0]  occ;
  logic         push;
  logic         pop;
  logic         drop;
  occ_state_e   occ_state;

  // Flags come only from registered occupancy, never from a or out_ready.
  always_comb begin
    occ_state = OCC_PARTIAL;
    if (occ == '0)                occ_state = OCC_EMPTY;
    else if (occ == OCC_FULL_LVL) occ_state = OCC_FULL;
  end

  assign out_valid = (occ_state != OCC_EMPTY);
  assign full      = (occ_state == OCC_FULL);

  assign val  = b ? (cnt - last_cnt) : cnt;
  assign pop  = out_valid & out_ready;
  assign push = a & (~full | pop);
  assign drop = a & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) last_cnt <= cnt;
      if (drop && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  tr_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (val),
    .rd_en   (pop),
    .rd_data (out_data),
    .occ     (occ)
  );
endmodule

// File: tb/tb_tr_delta_fifo.sv
// tb/tb_tr_delta_fifo.sv - randomized and directed bench for tr_delta_fifo with queue model
module tb_tr_delta_fifo;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] cnt;
  logic       a;
  logic       b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       full;
  logic [7:0] drop_cnt;

  int total;
  int bad;

  logic [7:0] q[$];
  logic [7:0] m_last;
  int         m_drops;

  tr_delta_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_last  = 8'd0;
    m_drops = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the sample rules, land 1ns after the edge.
  task automatic cycle(input logic ia, input logic ib, input logic [7:0] icnt, input logic irdy);
    logic       pop;
    logic       push;
    logic       drop;
    logic [7:0] v;
    a = ia; b = ib; cnt = icnt; out_ready = irdy;
    pop  = (q.size() != 0) && irdy;
    push = ia && ((q.size() < DEPTH) || pop);
    drop = ia && (q.size() == DEPTH) && !pop;
    v = ib ? icnt - m_last : icnt;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(v);
      m_last = icnt;
    end
    if (drop && m_drops < 255) m_drops++;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; a = 0; b = 0; cnt = 0; out_ready = 0;
    #2 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 0; b = 0; cnt = 0; out_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0d want 0", out_valid); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got %0d want 0", full); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_raw();
    do_reset();
    cycle(1, 0, 8'd5, 0);
    cycle(1, 0, 8'd6, 0);
    cycle(1, 0, 8'd7, 0);
    total++; if (full !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL raw_flags got v=%0d f=%0d want v=1 f=0", out_valid, full); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_data !== 8'(5 + i)) begin bad++; $display("FAIL raw_drain got %0d want %0d", out_data, 5 + i); end
      cycle(0, 0, 8'd0, 1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_empty got %0d want 0", out_valid); end
  endtask

  task automatic test_delta();
    do_reset();
    cycle(1, 1, 8'd10, 0);
    total++; if (out_data !== 8'd10 || out_valid !== 1'b1) begin bad++; $display("FAIL delta_first got %0d want 10", out_data); end
    cycle(1, 1, 8'd13, 0);
    cycle(0, 0, 8'd0, 1);
    total++; if (out_data !== 8'd3) begin bad++; $display("FAIL delta_second got %0d want 3", out_data); end
    cycle(0, 0, 8'd0, 1);
    cycle(1, 1, 8'd20, 0);
    total++; if (out_data !== 8'd7) begin bad++; $display("FAIL delta_last got %0d want 7", out_data); end
    cycle(0, 0, 8'd0, 1);
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(20 + i), 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'(30 + i), 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL drop_full got %0d want 1", full); end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL drop_count got %0d want 3", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== 8'(20 + i)) begin bad++; $display("FAIL drop_contents got %0d want %0d", out_data, 20 + i); end
      cycle(0, 0, 8'd0, 1);
    end
    cycle(1, 1, 8'd40, 0);
    total++; if (out_data !== 8'd17) begin bad++; $display("FAIL drop_last got %0d want 17", out_data); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(50 + i), 0);
    cycle(1, 0, 8'd60, 1);
    total++; if (full !== 1'b1 || drop_cnt !== 8'd0) begin bad++; $display("FAIL fullpop_flags got f=%0d d=%0d want f=1 d=0", full, drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== ((i == 3) ? 8'd60 : 8'(51 + i))) begin bad++; $display("FAIL fullpop_data got %0d want %0d", out_data, (i == 3) ? 60 : 51 + i); end
      cycle(0, 0, 8'd0, 1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got %0d want 0", out_valid); end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    cycle(1, 0, 8'd250, 0);
    cycle(1, 1, 8'd2, 1);
    total++; if (out_data !== 8'd8) begin bad++; $display("FAIL wrap_delta got %0d want 8", out_data); end
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(i), 0);
    for (int i = 0; i < 300; i++) cycle(1, 0, 8'(i), 0);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 0, 8'd11, 0);
    cycle(1, 0, 8'd12, 0);
    a = 0; out_ready = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got %0d want 1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL arst_immediate got v=%0d f=%0d want 0 0", out_valid, full); end
    #1 rst = 1'b0;
    model_clear();
    cycle(1, 0, 8'd77, 0);
    total++; if (out_data !== 8'd77 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_slot0 got %0d want 77", out_data); end
    cycle(0, 0, 8'd0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_single got %0d want 0", out_valid); end
  endtask

  task automatic test_random();
    logic ev;
    logic ef;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 2) == 0));
      ev = (q.size() != 0);
      ef = (q.size() == DEPTH);
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rand_valid cyc %0d got %0d want %0d", i, out_valid, ev); end
      total++; if (full !== ef) begin bad++; $display("FAIL rand_full cyc %0d got %0d want %0d", i, full, ef); end
      total++; if (drop_cnt !== 8'(m_drops)) begin bad++; $display("FAIL rand_drop cyc %0d got %0d want %0d", i, drop_cnt, m_drops); end
      if (ev) begin
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL rand_data cyc %0d got %0d want %0d", i, out_data, q[0]); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_raw();
    test_delta();
    test_full_drop();
    test_full_pop();
    test_wrap_sat();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
